// File: rtl/signed_multiplier_controller_if.sv
// rtl/signed_multiplier_controller_if.sv - operand, result and datapath signals of the signed multiplier controller
// The slave modport is the controller's view and the master modport is its environment.
interface signed_multiplier_controller_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        error;
  logic        busy;
  logic        dp_load;
  logic [7:0]  dp_multiplier;
  logic [7:0]  dp_multiplicand;
  logic        dp_done;
  logic [15:0] dp_result;

  modport slave (
    input  in_valid, a, b, out_ready, dp_done, dp_result,
    output in_ready, out_valid, product, error, busy, dp_load, dp_multiplier, dp_multiplicand
  );

  modport master (
    output in_valid, a, b, out_ready, dp_done, dp_result,
    input  in_ready, out_valid, product, error, busy, dp_load, dp_multiplier, dp_multiplicand
  );
endinterface

// File: rtl/signed_multiplier_controller.sv
// rtl/signed_multiplier_controller.sv - signed wrapper around an unsigned shift-add multiplier datapath
// Feeds operand magnitudes to the datapath, restores the sign and guards the wait with a watchdog.
module signed_multiplier_controller #(
  parameter int TIMEOUT_CYCLES = 12
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  signed_multiplier_controller_if.slave bus
);

  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t        state_q;
  logic [7:0]    mplier_q;
  logic [7:0]    mcand_q;
  logic          neg_q;
  logic [15:0]   product_q;
  logic          error_q;
  logic [WW-1:0] wdog_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      mplier_q  <= '0;
      mcand_q   <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
      error_q   <= 1'b0;
      wdog_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            // -128 negates to itself, which is the correct magnitude 0x80
            mplier_q <= bus.a[7] ? (~bus.a + 8'd1) : bus.a;
            mcand_q  <= bus.b[7] ? (~bus.b + 8'd1) : bus.b;
            neg_q    <= bus.a[7] ^ bus.b[7];
            error_q  <= 1'b0;
            state_q  <= S_LOAD;
          end
        end
        S_LOAD: begin
          wdog_q  <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.dp_done) begin
            state_q <= S_SETTLE;
          end else if (wdog_q == WDOG_LAST) begin
            product_q <= '0;
            error_q   <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            wdog_q <= wdog_q + WW'(1);
          end
        end
        S_SETTLE: begin
          // Result register lands on the edge after done, so it is valid only now
          product_q <= neg_q ? (~bus.dp_result + 16'd1) : bus.dp_result;
          state_q   <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready        = (state_q == S_IDLE);
  assign bus.busy            = (state_q != S_IDLE);
  assign bus.out_valid       = (state_q == S_DONE);
  assign bus.dp_load         = (state_q == S_LOAD);
  assign bus.dp_multiplier   = mplier_q;
  assign bus.dp_multiplicand = mcand_q;
  assign bus.product         = product_q;
  assign bus.error           = error_q;

endmodule
